// File: rtl/pc_fetch_gen.sv
// Fetch PC generator: sequential word fetch requests with redirect,
// flush, halt and a saturating redirect counter.
module pc_fetch_gen #(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 redirect_valid,
  input  logic [PC_WIDTH-1:0]  redirect_pc,
  input  logic                 halt,
  output logic                 if_req_valid,
  output logic [PC_WIDTH-1:0]  if_req_pc,
  input  logic                 if_req_ready,
  output logic                 flush_out,
  output logic                 misalign_err,
  output logic [CNT_WIDTH-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    REDIR,
    HALTED
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_nxt;

  assign if_req_pc = pc;

  // A redirect overrides everything, including a same-cycle handshake.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (redirect_valid) begin
      pc_nxt    = {redirect_pc[PC_WIDTH-1:2], 2'b00};
      state_nxt = REDIR;
    end else begin
      unique case (state)
        BOOT: state_nxt = halt ? HALTED : RUN;
        RUN: begin
          if (if_req_ready) begin
            pc_nxt    = pc + PC_WIDTH'(4);
            state_nxt = halt ? HALTED : RUN;
          end
        end
        REDIR:  state_nxt = halt ? HALTED : RUN;
        HALTED: state_nxt = halt ? HALTED : RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      if_req_valid <= 1'b0;
      flush_out    <= 1'b0;
      misalign_err <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      if_req_valid <= (state_nxt == RUN);
      flush_out    <= (state_nxt == REDIR);
      misalign_err <= redirect_valid && (|redirect_pc[1:0]);
      if (redirect_valid && !(&redirect_cnt))
        redirect_cnt <= redirect_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Randomized and directed bench for pc_fetch_gen with a queue-based
// scoreboard fed by an abstract output-level reference model.
module tb_pc_fetch_gen;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        if_req_valid;
  logic [31:0] if_req_pc;
  logic        if_req_ready;
  logic        flush_out;
  logic        misalign_err;
  logic [15:0] redirect_cnt;

  pc_fetch_gen #(
    .PC_WIDTH (32),
    .RESET_PC (32'h0000_0000),
    .CNT_WIDTH(16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .if_req_valid  (if_req_valid),
    .if_req_pc     (if_req_pc),
    .if_req_ready  (if_req_ready),
    .flush_out     (flush_out),
    .misalign_err  (misalign_err),
    .redirect_cnt  (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        flush;
    logic        mis;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model of the visible outputs; the fetch request stays posted while
  // it is not accepted, otherwise it is posted iff halt is low.
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_flush;
  logic        m_mis;
  int          m_cnt;

  task automatic cyc(input logic r, input logic rv,
                     input logic [31:0] rpc, input logic h,
                     input logic rdy);
    exp_t e;
    rst_n          = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    if_req_ready   = rdy;
    if (!r) begin
      m_pc    = 32'h0;
      m_valid = 1'b0;
      m_flush = 1'b0;
      m_mis   = 1'b0;
      m_cnt   = 0;
    end else if (rv) begin
      m_pc    = rpc & ~32'h3;
      m_valid = 1'b0;
      m_flush = 1'b1;
      m_mis   = (rpc % 4) != 0;
      m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end else begin
      if (m_valid && rdy) m_pc = m_pc + 32'd4;
      m_valid = (m_valid && !rdy) ? 1'b1 : !h;
      m_flush = 1'b0;
      m_mis   = 1'b0;
    end
    e.valid = m_valid;
    e.pc    = m_pc;
    e.flush = m_flush;
    e.mis   = m_mis;
    e.cnt   = m_cnt[15:0];
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (if_req_valid !== e.valid) begin
        errors++;
        $display("FAIL valid: got %b expected %b t=%0t",
                 if_req_valid, e.valid, $time);
      end
      if (if_req_pc !== e.pc) begin
        errors++;
        $display("FAIL pc: got %h expected %h t=%0t",
                 if_req_pc, e.pc, $time);
      end
      if (flush_out !== e.flush) begin
        errors++;
        $display("FAIL flush: got %b expected %b t=%0t",
                 flush_out, e.flush, $time);
      end
      if (misalign_err !== e.mis) begin
        errors++;
        $display("FAIL misalign: got %b expected %b t=%0t",
                 misalign_err, e.mis, $time);
      end
      if (redirect_cnt !== e.cnt) begin
        errors++;
        $display("FAIL cnt: got %h expected %h t=%0t",
                 redirect_cnt, e.cnt, $time);
      end
      if (flush_out === 1'b1 && if_req_valid === 1'b1) begin
        errors++;
        $display("FAIL excl: flush and valid both 1 t=%0t", $time);
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    if_req_ready   = 1'b0;
    m_pc = 0; m_valid = 0; m_flush = 0; m_mis = 0; m_cnt = 0;

    // reset then sequential fetch 0,4,8
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    // backpressure at 0x8
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    // redirect with same-cycle ready at 0x10
    cyc(1, 1, 32'h400, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    // misaligned, then back-to-back redirects
    cyc(1, 1, 32'h402, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 32'h100, 0, 1);
    cyc(1, 1, 32'h200, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    // halt with backpressure, redirect while halted
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 1);
    cyc(1, 0, 0, 1, 1);
    cyc(1, 1, 32'h800, 1, 1);
    cyc(1, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    // wrap at top of address space
    cyc(1, 1, 32'hFFFF_FFFC, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    // reset during REDIR
    cyc(1, 1, 32'h1234, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    // saturate the counter
    for (int i = 0; i < 65540; i++)
      cyc(1, 1, {$urandom} & 32'hFFFF_FFF0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    // random traffic
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic r, rv, h, rdy;
      r   = ($urandom_range(0, 199) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      h   = ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      cyc(r, rv, $urandom, h, rdy);
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
